// File: rtl/ysyx_24110006_lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - load-type (funct3) constants
//   - FSM state encoding
//   - default bus timeout in cycles
package ysyx_24110006_pkg;

    localparam logic [2:0] LdLb  = 3'b000;
    localparam logic [2:0] LdLh  = 3'b001;
    localparam logic [2:0] LdLw  = 3'b010;
    localparam logic [2:0] LdLbu = 3'b100;
    localparam logic [2:0] LdLhu = 3'b101;

    localparam int unsigned TimeoutDefault = 255;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/ysyx_24110006_lsu_if.sv
// Bundles every non-clock/reset signal of the LSU.
//   master : LSU side (execute input, memory bus master, write-back output)
//   slave  : environment side (execute stage, memory, WBU)
interface ysyx_24110006_lsu_if;

    // Execute -> LSU
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_result;
    logic [31:0] i_reg_src2;
    logic        i_mem_ren;
    logic        i_mem_wen;
    logic [3:0]  i_mem_wmask;
    logic [2:0]  i_mem_read_t;
    logic        i_reg_wen;
    logic [4:0]  i_rd;

    // Memory bus
    logic        o_mem_req;
    logic        i_mem_gnt;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_rsp;
    logic [31:0] i_mem_rdata;
    logic        i_mem_err;

    // LSU -> WBU
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_wb_data;
    logic [4:0]  o_rd;
    logic        o_reg_wen;
    logic        o_err;

    modport master (
        input  i_valid, i_result, i_reg_src2, i_mem_ren, i_mem_wen, i_mem_wmask,
               i_mem_read_t, i_reg_wen, i_rd, i_mem_gnt, i_mem_rsp, i_mem_rdata,
               i_mem_err, i_ready,
        output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
               o_valid, o_wb_data, o_rd, o_reg_wen, o_err
    );

    modport slave (
        output i_valid, i_result, i_reg_src2, i_mem_ren, i_mem_wen, i_mem_wmask,
               i_mem_read_t, i_reg_wen, i_rd, i_mem_gnt, i_mem_rsp, i_mem_rdata,
               i_mem_err, i_ready,
        input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
               o_valid, o_wb_data, o_rd, o_reg_wen, o_err
    );

endinterface

// File: rtl/ysyx_24110006_lsu_align.sv
// Combinational data alignment for the LSU.
//   i_addr       byte address (low two bits select the lane)
//   i_src2       unshifted store data
//   i_wmask      store mask (0001 byte, 0011 half, 1111 word)
//   i_read_t     load type (funct3)
//   i_is_store   selects store sizing for the misalign check
//   i_rdata      full read word from memory
//   o_wdata      store data shifted into its byte lanes
//   o_wstrb      byte strobes
//   o_rdata      extracted and sign/zero-extended load value
//   o_misalign   half access on odd address or word access not word aligned
module ysyx_24110006_lsu_align
    import ysyx_24110006_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [31:0] i_src2,
    input  logic [3:0]  i_wmask,
    input  logic [2:0]  i_read_t,
    input  logic        i_is_store,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [4:0]  shamt;
    logic [31:0] lane;
    logic        is_half;
    logic        is_word;

    always_comb begin
        shamt   = {i_addr[1:0], 3'b000};
        o_wdata = i_src2 << shamt;
        o_wstrb = i_wmask << i_addr[1:0];

        lane = i_rdata >> shamt;
        case (i_read_t)
            LdLb:    o_rdata = {{24{lane[7]}}, lane[7:0]};
            LdLh:    o_rdata = {{16{lane[15]}}, lane[15:0]};
            LdLbu:   o_rdata = {24'd0, lane[7:0]};
            LdLhu:   o_rdata = {16'd0, lane[15:0]};
            default: o_rdata = lane;  // LW and the unused encodings
        endcase

        // Loads: funct3[1] set means word (010/011/110/111), 01 in the low bits means half.
        if (i_is_store) begin
            is_half = (i_wmask == 4'b0011);
            is_word = (i_wmask == 4'b1111);
        end else begin
            is_half = (i_read_t[1:0] == 2'b01);
            is_word = i_read_t[1];
        end
        o_misalign = (is_half && i_addr[0]) || (is_word && (i_addr[1:0] != 2'b00));
    end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store stage between execute and write-back.
//   i_clock / i_reset  clock, asynchronous active-high reset
//   bus                execute handshake, single-outstanding req/gnt/rsp memory port,
//                      and valid/ready write-back output (see ysyx_24110006_lsu_if)
// Non-memory ops pass i_result through; misaligned accesses complete with o_err and
// no bus activity; a stalled bus aborts with o_err after TIMEOUT cycles.
module ysyx_24110006_lsu
    import ysyx_24110006_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input logic                 i_clock,
    input logic                 i_reset,
    ysyx_24110006_lsu_if.master bus
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] src2_q, src2_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [2:0]  read_t_q, read_t_d;
    logic        wen_q, wen_d;
    logic        reg_wen_q, reg_wen_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wb_q, wb_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    // The aligner sees the live inputs while idle (for the misalign decision at
    // capture) and the captured transaction afterwards.
    logic        idle;
    logic [31:0] al_addr, al_src2, al_wdata, al_rdata;
    logic [3:0]  al_wmask, al_wstrb;
    logic [2:0]  al_read_t;
    logic        al_store, al_misalign;
    logic        timed_out;

    always_comb begin
        idle      = (state_q == StIdle);
        al_addr   = idle ? bus.i_result     : addr_q;
        al_src2   = idle ? bus.i_reg_src2   : src2_q;
        al_wmask  = idle ? bus.i_mem_wmask  : wmask_q;
        al_read_t = idle ? bus.i_mem_read_t : read_t_q;
        al_store  = idle ? bus.i_mem_wen    : wen_q;
    end

    ysyx_24110006_lsu_align u_align (
        .i_addr     (al_addr),
        .i_src2     (al_src2),
        .i_wmask    (al_wmask),
        .i_read_t   (al_read_t),
        .i_is_store (al_store),
        .i_rdata    (bus.i_mem_rdata),
        .o_wdata    (al_wdata),
        .o_wstrb    (al_wstrb),
        .o_rdata    (al_rdata),
        .o_misalign (al_misalign)
    );

    assign timed_out = (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        src2_d    = src2_q;
        wmask_d   = wmask_q;
        read_t_d  = read_t_q;
        wen_d     = wen_q;
        reg_wen_d = reg_wen_q;
        rd_d      = rd_q;
        wb_d      = wb_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    addr_d    = bus.i_result;
                    src2_d    = bus.i_reg_src2;
                    wmask_d   = bus.i_mem_wmask;
                    read_t_d  = bus.i_mem_read_t;
                    wen_d     = bus.i_mem_wen;
                    reg_wen_d = bus.i_reg_wen;
                    rd_d      = bus.i_rd;
                    cnt_d     = 8'd0;
                    wb_d      = 32'd0;
                    err_d     = 1'b0;
                    if (!bus.i_mem_ren && !bus.i_mem_wen) begin
                        wb_d    = bus.i_result;
                        state_d = StDone;
                    end else if (al_misalign) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (bus.i_mem_gnt) begin
                    cnt_d   = 8'd0;
                    state_d = StWait;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    wb_d    = 32'd0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWait: begin
                if (bus.i_mem_rsp) begin
                    wb_d    = wen_q ? 32'd0 : al_rdata;
                    err_d   = bus.i_mem_err;
                    state_d = StDone;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    wb_d    = 32'd0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                if (bus.i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= StIdle;
            addr_q    <= 32'd0;
            src2_q    <= 32'd0;
            wmask_q   <= 4'd0;
            read_t_q  <= 3'd0;
            wen_q     <= 1'b0;
            reg_wen_q <= 1'b0;
            rd_q      <= 5'd0;
            wb_q      <= 32'd0;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            src2_q    <= src2_d;
            wmask_q   <= wmask_d;
            read_t_q  <= read_t_d;
            wen_q     <= wen_d;
            reg_wen_q <= reg_wen_d;
            rd_q      <= rd_d;
            wb_q      <= wb_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.o_ready     = idle;
    assign bus.o_mem_req   = (state_q == StReq);
    assign bus.o_mem_we    = wen_q;
    assign bus.o_mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.o_mem_wdata = al_wdata;
    assign bus.o_mem_wstrb = al_wstrb;
    assign bus.o_valid     = (state_q == StDone);
    assign bus.o_wb_data   = wb_q;
    assign bus.o_rd        = rd_q;
    assign bus.o_err       = err_q;
    assign bus.o_reg_wen   = reg_wen_q && !err_q;

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
module tb_ysyx_24110006_lsu;

    typedef struct packed {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rwen;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    int   rdy_mode;  // 0: always ready, 1: random, 2: never
    exp_t sb[$];

    ysyx_24110006_lsu_if bus ();

    ysyx_24110006_lsu dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic wen, input logic [3:0] mask,
                                    input logic [2:0] rt);
        if (wen) return (mask == 4'h1) ? 1 : (mask == 4'h3) ? 2 : 4;
        case (rt)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] rt, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        int          k;
        k = int'(addr % 4);
        v = rdata >> (8 * k);
        case (rt)
            3'd0:    return 32'(int'($signed(v[7:0])));
            3'd1:    return 32'(int'($signed(v[15:0])));
            3'd4:    return v & 32'h0000_00FF;
            3'd5:    return v & 32'h0000_FFFF;
            default: return v;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] res, input logic ren, input logic wen,
                                   input logic [3:0] mask, input logic [2:0] rt,
                                   input logic rwen, input logic [4:0] rd,
                                   input logic [31:0] rdata, input logic berr);
        exp_t e;
        e.rd = rd;
        if (!ren && !wen) begin
            e.wb  = res;
            e.err = 1'b0;
        end else if ((res % acc_size(wen, mask, rt)) != 0) begin
            e.wb  = 32'd0;
            e.err = 1'b1;
        end else if (wen) begin
            e.wb  = 32'd0;
            e.err = berr;
        end else begin
            e.wb  = load_val(rt, res, rdata);
            e.err = berr;
        end
        e.rwen = rwen && !e.err;
        return e;
    endfunction

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = ($urandom_range(0, 3) != 0);
                default: bus.i_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        hold_prev;
    logic [31:0] hold_wb;
    logic [4:0]  hold_rd;
    logic        hold_err, hold_rwen;

    initial hold_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk1("hold_valid", bus.o_valid, 1'b1);
                chk("hold_wb", bus.o_wb_data, hold_wb);
                chk("hold_rd", 32'(bus.o_rd), 32'(hold_rd));
                chk1("hold_err", bus.o_err, hold_err);
                chk1("hold_rwen", bus.o_reg_wen, hold_rwen);
            end
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got wb %h expected no output",
                             bus.o_wb_data);
                end else begin
                    e = sb.pop_front();
                    chk("wb_data", bus.o_wb_data, e.wb);
                    chk("rd", 32'(bus.o_rd), 32'(e.rd));
                    chk1("reg_wen", bus.o_reg_wen, e.rwen);
                    chk1("err", bus.o_err, e.err);
                end
            end
            hold_prev = bus.o_valid && !bus.i_ready;
            if (hold_prev) begin
                chk1("ready_low_in_done", bus.o_ready, 1'b0);
                hold_wb   = bus.o_wb_data;
                hold_rd   = bus.o_rd;
                hold_err  = bus.o_err;
                hold_rwen = bus.o_reg_wen;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk1("idle_reached", bus.o_ready, 1'b1);
    endtask

    // mode: 0 normal, 1 never grant, 2 never respond, 3 stop in WAIT, 4 stop in REQ
    task automatic run_txn(input logic [31:0] res, input logic [31:0] src2, input logic ren,
                           input logic wen, input logic [3:0] mask, input logic [2:0] rt,
                           input logic rwen, input logic [4:0] rd, input int gnt_dly,
                           input int rsp_dly, input logic [31:0] rdata, input logic berr,
                           input int mode);
        exp_t        e;
        logic        mis;
        logic [31:0] eaddr;
        int          k;
        int          n;
        wait_idle();
        e   = model(res, ren, wen, mask, rt, rwen, rd, rdata, berr);
        mis = (ren || wen) && ((res % acc_size(wen, mask, rt)) != 0);
        if (mode == 1 || mode == 2) begin
            e.wb   = 32'd0;
            e.err  = 1'b1;
            e.rwen = 1'b0;
        end
        bus.i_valid      = 1'b1;
        bus.i_result     = res;
        bus.i_reg_src2   = src2;
        bus.i_mem_ren    = ren;
        bus.i_mem_wen    = wen;
        bus.i_mem_wmask  = mask;
        bus.i_mem_read_t = rt;
        bus.i_reg_wen    = rwen;
        bus.i_rd         = rd;
        if (mode < 3) sb.push_back(e);
        step();
        // scramble inputs so the DUT must rely on its captured copy
        bus.i_valid      = 1'b0;
        bus.i_result     = $urandom;
        bus.i_reg_src2   = $urandom;
        bus.i_mem_wmask  = 4'($urandom_range(0, 15));
        bus.i_mem_read_t = 3'($urandom_range(0, 7));
        bus.i_rd         = 5'($urandom_range(0, 31));
        if (!(ren || wen) || mis) begin
            chk1("done_next_cycle", bus.o_valid, 1'b1);
            chk1("no_bus_req", bus.o_mem_req, 1'b0);
            return;
        end
        if (mode == 4) return;
        eaddr = res & 32'hFFFF_FFFC;
        k     = int'(res % 4);
        if (mode == 1) begin
            chk1("req_held", bus.o_mem_req, 1'b1);
            n = 0;
            while (bus.o_valid !== 1'b1 && n < 300) begin
                step();
                n++;
            end
            chk1("req_timeout_window", (n >= 254 && n <= 256), 1'b1);
            return;
        end
        for (int i = 0; i < gnt_dly; i++) begin
            chk1("req_stall", bus.o_mem_req, 1'b1);
            chk("addr_stall", bus.o_mem_addr, eaddr);
            step();
        end
        chk1("req", bus.o_mem_req, 1'b1);
        chk("addr", bus.o_mem_addr, eaddr);
        chk1("we", bus.o_mem_we, wen);
        if (wen) begin
            chk("wdata", bus.o_mem_wdata, src2 << (8 * k));
            chk("wstrb", 32'(bus.o_mem_wstrb), 32'(4'(mask << k)));
        end
        bus.i_mem_gnt   = 1'b1;
        bus.i_mem_rsp   = 1'($urandom_range(0, 1));  // must be ignored in the grant cycle
        bus.i_mem_err   = 1'b1;
        bus.i_mem_rdata = $urandom;
        step();
        bus.i_mem_gnt = 1'b0;
        bus.i_mem_rsp = 1'b0;
        bus.i_mem_err = 1'b0;
        chk1("wait_no_req", bus.o_mem_req, 1'b0);
        chk1("gnt_rsp_ignored", bus.o_valid, 1'b0);
        if (mode == 3) return;
        if (mode == 2) begin
            n = 0;
            while (bus.o_valid !== 1'b1 && n < 300) begin
                step();
                n++;
            end
            chk1("rsp_timeout_window", (n >= 254 && n <= 256), 1'b1);
            return;
        end
        for (int i = 0; i < rsp_dly; i++) step();
        bus.i_mem_rsp   = 1'b1;
        bus.i_mem_rdata = rdata;
        bus.i_mem_err   = berr;
        step();
        bus.i_mem_rsp   = 1'b0;
        bus.i_mem_err   = 1'b0;
        bus.i_mem_rdata = $urandom;
        chk1("valid_after_rsp", bus.o_valid, 1'b1);
    endtask

    task automatic reset_mid(input int mode);
        run_txn(32'h8000_0010, 32'h0, 1'b1, 1'b0, 4'hF, 3'd2, 1'b1, 5'd9, 0, 0, 32'h0, 1'b0,
                mode);
        rst = 1'b1;
        #1;
        chk1("rst_req_drop", bus.o_mem_req, 1'b0);
        chk1("rst_valid_drop", bus.o_valid, 1'b0);
        sb.delete();
        step();
        rst = 1'b0;
        bus.i_mem_rsp   = 1'b1;  // late response from the aborted access
        bus.i_mem_rdata = 32'h1111_1111;
        step();
        bus.i_mem_rsp = 1'b0;
        chk1("rst_rsp_ignored", bus.o_valid, 1'b0);
        chk1("rst_ready", bus.o_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic [3:0]  mask;
        logic        ren, wen;
        int          kind;
        int          mi;
        n_vec            = 0;
        n_bad            = 0;
        rdy_mode         = 0;
        rst              = 1'b1;
        bus.i_valid      = 1'b0;
        bus.i_result     = 32'd0;
        bus.i_reg_src2   = 32'd0;
        bus.i_mem_ren    = 1'b0;
        bus.i_mem_wen    = 1'b0;
        bus.i_mem_wmask  = 4'd0;
        bus.i_mem_read_t = 3'd0;
        bus.i_reg_wen    = 1'b0;
        bus.i_rd         = 5'd0;
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rsp    = 1'b0;
        bus.i_mem_rdata  = 32'd0;
        bus.i_mem_err    = 1'b0;
        bus.i_ready      = 1'b0;
        step();
        chk1("rst_ready", bus.o_ready, 1'b1);
        chk1("rst_req", bus.o_mem_req, 1'b0);
        chk1("rst_valid", bus.o_valid, 1'b0);
        chk1("rst_err", bus.o_err, 1'b0);
        chk1("rst_rwen", bus.o_reg_wen, 1'b0);
        chk1("rst_we", bus.o_mem_we, 1'b0);
        chk("rst_rd", 32'(bus.o_rd), 32'd0);
        chk("rst_wb", bus.o_wb_data, 32'd0);
        step();
        rst = 1'b0;
        step();

        // pass-through, byte store, loads, misaligned word load
        run_txn(32'h0000_1234, 32'h0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 5'd5, 0, 0, 32'h0, 1'b0, 0);
        run_txn(32'h8000_0003, 32'hAABB_CCDD, 1'b0, 1'b1, 4'b0001, 3'd0, 1'b0, 5'd0, 0, 0,
                32'h0, 1'b0, 0);
        run_txn(32'h8000_0002, 32'h0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b1, 5'd1, 0, 0, 32'h0080_FF00,
                1'b0, 0);
        run_txn(32'h8000_0002, 32'h0, 1'b1, 1'b0, 4'h0, 3'd4, 1'b1, 5'd2, 0, 0, 32'h0080_FF00,
                1'b0, 0);
        run_txn(32'h8000_0002, 32'h0, 1'b1, 1'b0, 4'h0, 3'd5, 1'b1, 5'd3, 0, 0, 32'h0080_FF00,
                1'b0, 0);
        run_txn(32'h8000_0002, 32'h0, 1'b1, 1'b0, 4'h0, 3'd2, 1'b1, 5'd4, 0, 0, 32'h0, 1'b0, 0);
        run_txn(32'h8000_0001, 32'h1234, 1'b0, 1'b1, 4'b0011, 3'd0, 1'b1, 5'd6, 0, 0, 32'h0,
                1'b0, 0);

        // slow grant with bus error, then both timeout flavours
        run_txn(32'h8000_0040, 32'h0, 1'b1, 1'b0, 4'h0, 3'd2, 1'b1, 5'd7, 3, 1, 32'hDEAD_BEEF,
                1'b1, 0);
        run_txn(32'h8000_0044, 32'h0, 1'b1, 1'b0, 4'h0, 3'd2, 1'b1, 5'd8, 0, 0, 32'h0, 1'b0, 2);
        run_txn(32'h8000_0048, 32'h5, 1'b0, 1'b1, 4'hF, 3'd0, 1'b1, 5'd10, 0, 0, 32'h0, 1'b0, 1);

        // stall in DONE for four cycles
        rdy_mode = 2;
        step();
        step();
        run_txn(32'h0000_CAFE, 32'h0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 5'd11, 0, 0, 32'h0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            chk1("stall_valid", bus.o_valid, 1'b1);
            chk1("stall_ready", bus.o_ready, 1'b0);
            chk("stall_wb", bus.o_wb_data, 32'h0000_CAFE);
            step();
        end
        rdy_mode = 0;

        // asynchronous reset while waiting for response, and while requesting
        reset_mid(3);
        reset_mid(4);
        run_txn(32'h0000_0777, 32'h0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 5'd12, 0, 0, 32'h0, 1'b0, 0);

        // randomized traffic
        rdy_mode = 1;
        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 3));
            ren  = (kind == 1 || kind == 3);
            wen  = (kind >= 2);
            mi   = int'($urandom_range(0, 2));
            mask = (mi == 0) ? 4'h1 : (mi == 1) ? 4'h3 : 4'hF;
            res  = $urandom;
            if ($urandom_range(0, 3) != 0) res = res & 32'hFFFF_FFFC;
            run_txn(res, $urandom, ren, wen, mask, 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                    ($urandom_range(0, 7) == 0), 0);
        end

        rdy_mode = 0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
